mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle RV32M multiply/divide unit sitting beside `alu` in the execute stage. The decoder routes the eight M-extension operations here instead of to the ALU. The core stalls while `ready_o` is low and writes back `result_o` when `valid_o` pulses. Signed operations are handled by magnitude conversion, 32 radix-2 iterations on an internal 33-bit add/sub datapath, and a final sign fix-up.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  operation request; accepted in the cycle where `req_i && ready_o`.
- `mdu_op_i`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a_i`  in  32  rs1 operand; sampled only in the accept cycle.
- `b_i`  in  32  rs2 operand; sampled only in the accept cycle.
- `flush_i`  in  1  synchronous abort of the operation in flight.
- `ready_o`  out  1  high only in IDLE.
- `valid_o`  out  1  one-cycle result strobe.
- `result_o`  out  32  registered result. Holds its value until the next `valid_o`.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE, on accept:
  - Latch op and operands.
  - Record `sign_a` = a[31] for MULH, MULHSU, DIV, REM; `sign_b` = b[31] for MULH, DIV, REM.
  - Special cases go directly to DONE with the result loaded:
    - DIV/DIVU by 0: all-ones.
    - REM/REMU by 0: a.
    - DIV 0x80000000 / 0xFFFFFFFF: 0x80000000.
    - REM 0x80000000 / 0xFFFFFFFF: 0.
  - Every other accept goes to PREP.
- PREP: replace each signed operand with its magnitude (two's-complement negate when the sign bit is recorded). Clear the 64-bit accumulator and the 6-bit iteration counter. Go to RUN.
- RUN, 32 iterations, counter 0..31. Go to FIX when the counter reaches 31.
  - Multiply: shift-add on a 64-bit {hi, lo} product; 33-bit add keeps the carry.
  - Divide: restoring. Shift {rem, quo} left by 1; the 33-bit trial subtract rem − divisor sets the new quotient bit from the non-negative result.
- FIX:
  - Multiply: negate the 64-bit product if `sign_a ^ sign_b`. MUL selects the low word; MULH, MULHSU and MULHU select the high word.
  - DIV: negate the quotient if `sign_a ^ sign_b`.
  - REM: negate the remainder if `sign_a`.
  - Load `result_o`.
- DONE: `valid_o` = 1 for this cycle only, then go to IDLE. `ready_o` = 0 in DONE, so there is no accept in the same cycle as `valid_o`.
- `flush_i` high in any non-IDLE state: next state IDLE, no `valid_o`, `result_o` unchanged. `flush_i` has priority over the normal transition. `flush_i` in IDLE blocks an accept in that cycle.
- Async reset, from any state including mid-RUN, forces:
  - state IDLE, `ready_o` = 1, `valid_o` = 0, `result_o` = 0;
  - all internal registers cleared.

## Timing
- Accept cycle = k.
- Normal path: PREP k+1, RUN k+2..k+33, FIX k+34, DONE k+35. `valid_o` is high in cycle k+35 only.
- Special-case path: DONE in k+1, so `valid_o` is high in cycle k+1.
- `ready_o` returns high in the cycle after `valid_o`. The earliest next accept is that cycle; `req_i` held high gives back-to-back operations with a 36-cycle period.
- `a_i`, `b_i` and `mdu_op_i` may change freely after the accept cycle without affecting the result.
- `result_o` changes only on the clock edge that starts DONE.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), accept in cycle k:
  - `result_o` = 0xFFFFFFEB with `valid_o` high exactly in cycle k+35;
  - `ready_o` low in k+1..k+35.
- Multiply high words:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF;
  - MUL 0x12345678 × 0x9ABCDEF0 → 0x242D2080.
- Signed divide:
  - DIV −7/2 → 0xFFFFFFFD;
  - REM −7/2 → 0xFFFFFFFF;
  - DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF;
  - REMU 100/7 → 2.
- Special cases, each with `valid_o` in cycle k+1:
  - DIVU 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM 0x80000000/0xFFFFFFFF → 0.
- Abort and reset:
  - `flush_i` pulsed at RUN iteration 10 → no `valid_o`; `ready_o` high next cycle; `result_o` keeps its previous value. A following DIVU 9/3 still returns 3.
  - `rst_i` asserted mid-RUN asynchronously clears all outputs to their reset values.
- Back-to-back: `req_i` held high for two MULs with operands changed after each accept → two correct `valid_o` pulses 36 cycles apart.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: request/result bundle between the execute stage
// and the multi-cycle RV32M multiply/divide sequencer.
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic [2:0]      mdu_op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            ready_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output req_i,
        output mdu_op_i,
        output a_i,
        output b_i,
        output flush_i,
        input  ready_o,
        input  valid_o,
        input  result_o
    );

    modport slave (
        input  req_i,
        input  mdu_op_i,
        input  a_i,
        input  b_i,
        input  flush_i,
        output ready_o,
        output valid_o,
        output result_o
    );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M unit, radix-2 shift-add multiply
// and restoring divide on magnitudes with a final sign fix-up.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    mdu_sequencer_if.slave mdu
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q;
    state_t state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [5:0]        cnt_q;
    logic [XLEN-1:0]   result_q;

    logic            ready;
    logic            valid;
    logic            accept;
    logic            sign_a_in;
    logic            sign_b_in;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   rem_res;
    logic [XLEN-1:0]   fix_res;

    assign accept = mdu.req_i && ready && !mdu.flush_i;

    // Decode sign handling and the results that bypass the iterations.
    always_comb begin
        sign_a_in = 1'b0;
        sign_b_in = 1'b0;
        if (mdu.mdu_op_i == OP_MULH || mdu.mdu_op_i == OP_MULHSU ||
            mdu.mdu_op_i == OP_DIV  || mdu.mdu_op_i == OP_REM)
            sign_a_in = mdu.a_i[XLEN-1];
        if (mdu.mdu_op_i == OP_MULH || mdu.mdu_op_i == OP_DIV ||
            mdu.mdu_op_i == OP_REM)
            sign_b_in = mdu.b_i[XLEN-1];

        div_zero = mdu.mdu_op_i[2] && (mdu.b_i == '0);
        div_ovf  = (mdu.mdu_op_i == OP_DIV || mdu.mdu_op_i == OP_REM) &&
                   (mdu.a_i == INT_MIN) && (mdu.b_i == ALL_ONES);
        special  = div_zero || div_ovf;

        special_res = '0;
        unique case (1'b1)
            div_zero && !mdu.mdu_op_i[1]: special_res = ALL_ONES;
            div_zero &&  mdu.mdu_op_i[1]: special_res = mdu.a_i;
            div_ovf  && !mdu.mdu_op_i[1]: special_res = INT_MIN;
            default:                      special_res = '0;
        endcase
    end

    // One radix-2 step for each of multiply and restoring divide.
    always_comb begin
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   ({(XLEN+1){b_q[0]}} & {1'b0, a_q});
        mul_next = {sum, acc_q[XLEN-1:1]};

        // The shifted remainder can reach bit XLEN, in which case it is
        // always at least the divisor.
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        trial    = rem_sh - {1'b0, b_q};
        q_bit    = rem_sh[XLEN] || !trial[XLEN];
        rem_new  = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_next = {rem_new, acc_q[XLEN-2:0], q_bit};
    end

    // Sign fix-up and word select for the final result.
    always_comb begin
        prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] :
                                     prod[2*XLEN-1:XLEN];
        div_res = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] :
                                          acc_q[XLEN-1:0];
        rem_res = sign_a_q ? -acc_q[2*XLEN-1:XLEN] :
                             acc_q[2*XLEN-1:XLEN];
        fix_res = mul_res;
        unique case (1'b1)
            !op_q[2]:           fix_res = mul_res;
            op_q[2] && !op_q[1]: fix_res = div_res;
            default:            fix_res = rem_res;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state; an abort overrides every normal transition.
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && mdu.flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept)
                    state_d = special ? S_DONE : S_PREP;
                S_PREP: state_d = S_RUN;
                S_RUN:  if (cnt_q == 6'd31)
                    state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready = (state_q == S_IDLE);
        valid = (state_q == S_DONE);
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= mdu.mdu_op_i;
                        a_q      <= mdu.a_i;
                        b_q      <= mdu.b_i;
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        if (special)
                            result_q <= special_res;
                    end
                end
                S_PREP: begin
                    a_q   <= sign_a_q ? -a_q : a_q;
                    b_q   <= sign_b_q ? -b_q : b_q;
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                S_RUN: begin
                    if (op_q[2]) begin
                        acc_q <= div_next;
                        a_q   <= a_q << 1;
                    end else begin
                        acc_q <= mul_next;
                        b_q   <= b_q >> 1;
                    end
                    cnt_q <= cnt_q + 6'd1;
                end
                S_FIX: begin
                    if (!mdu.flush_i)
                        result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign mdu.ready_o  = ready;
    assign mdu.valid_o  = valid;
    assign mdu.result_o = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed RV32M vectors with a per-cycle compare
// against a transaction-level model of the sequencer.
module tb_mdu_sequencer;
    logic clk;
    logic rst;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .mdu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cyc      = 0;
    int          due      = 0;
    bit          pending  = 1'b0;
    logic [31:0] exp_res  = '0;
    logic [31:0] last_res = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            3'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                return p[63:32];
            end
            3'd2: begin
                p = {{32{a[31]}}, a} * {32'b0, b};
                return p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (op[2] && b == 0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) &&
               a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Transaction model: busy window from accept to result strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  = 1'b0;
            last_res = '0;
        end else begin
            cyc++;
            if (pending && (cyc - 1) == due) begin
                pending = 1'b0;
            end else if (pending && bus.flush_i) begin
                pending = 1'b0;
            end else if (!pending && bus.req_i && !bus.flush_i) begin
                pending = 1'b1;
                exp_res = model(bus.mdu_op_i, bus.a_i, bus.b_i);
                due = is_special(bus.mdu_op_i, bus.a_i, bus.b_i) ?
                      cyc : cyc + 34;
            end
            if (pending && cyc == due)
                last_res = exp_res;
        end
    end

    // Compare DUT outputs with the model every cycle.
    always @(negedge clk) begin
        chk("ready", {31'b0, bus.ready_o}, {31'b0, !pending});
        chk("valid", {31'b0, bus.valid_o},
            {31'b0, pending && cyc == due});
        chk("result", bus.result_o, last_res);
    end

    task automatic wait_valid(output int t);
        int n;
        n = 0;
        while (!bus.valid_o && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!bus.valid_o)
            chk("valid_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input string nm);
        int t0;
        int t1;
        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.mdu_op_i = op;
        bus.a_i      = a;
        bus.b_i      = b;
        t0 = cyc;
        @(negedge clk);
        bus.req_i    = 1'b0;
        bus.mdu_op_i = 3'($urandom);
        bus.a_i      = $urandom;
        bus.b_i      = $urandom;
        wait_valid(t1);
        chk({nm, "_res"}, bus.result_o, exp);
        chk({nm, "_lat"}, 32'(t1 - t0), 32'(lat));
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target)
            chk("cyc_timeout", 32'(cyc), 32'(target));
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        bus.req_i    = 1'b0;
        bus.mdu_op_i = '0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.flush_i  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, "mul_neg");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, "mulhsu");
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 35, "mul_lo");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "div_neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, "rem_neg");
        run_op(3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 35, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 35, "remu");

        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_z");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_z");

        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.mdu_op_i = 3'd5;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        t0 = cyc;
        @(negedge clk);
        bus.req_i = 1'b0;
        wait_cyc(t0 + 12);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("flush_result", bus.result_o, 32'd5);
        repeat (40) @(negedge clk);
        chk("flush_keep", bus.result_o, 32'd5);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 35, "divu_after");

        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.flush_i  = 1'b1;
        bus.mdu_op_i = 3'd5;
        bus.a_i      = 32'd1;
        bus.b_i      = 32'd1;
        @(negedge clk);
        bus.req_i   = 1'b0;
        bus.flush_i = 1'b0;
        chk("idle_flush_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("idle_flush_valid", {31'b0, bus.valid_o}, 32'd0);

        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.mdu_op_i = 3'd0;
        bus.a_i      = 32'd11;
        bus.b_i      = 32'd13;
        t0 = cyc;
        @(negedge clk);
        bus.req_i = 1'b0;
        wait_cyc(t0 + 15);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", {31'b0, bus.ready_o}, 32'd1);
        chk("arst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("arst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        bus.req_i    = 1'b1;
        bus.mdu_op_i = 3'd0;
        bus.a_i      = 32'd3;
        bus.b_i      = 32'd5;
        t0 = cyc;
        @(negedge clk);
        bus.a_i = 32'h1234;
        bus.b_i = 32'h10;
        wait_valid(t1);
        chk("b2b_first", bus.result_o, 32'd15);
        chk("b2b_first_lat", 32'(t1 - t0), 32'd35);
        @(negedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        bus.a_i   = $urandom;
        bus.b_i   = $urandom;
        wait_valid(t2);
        chk("b2b_second", bus.result_o, 32'h0001_2340);
        chk("b2b_period", 32'(t2 - t1), 32'd36);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
